// File: rtl/led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_arbiter: fixed-priority LED sharing with minimum hold and blinking   |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
module led_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 12000,
  parameter int MIN_HOLD = 250,
  parameter int PHASE_W  = 10,
  parameter int SLOW_BIT = 9,
  parameter int FAST_BIT = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       mode,
  output logic                     led,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     tick
);

  localparam int OWN_W   = $clog2(N_REQ);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 led_q, led_d;
  logic [OWN_W-1:0]     win;
  logic                 any_req;
  logic [1:0]           own_mode;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    win     = '0;
    any_req = |req;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) win = OWN_W'(i);
    end
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    state_d = state_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    owner_d = owner_q;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_d = S_OWN;
            owner_d = win;
            hold_d  = '0;
            phase_d = '0;
          end
        end
        S_OWN: begin
          // A dropped request releases at once, regardless of hold time.
          if (!req[owner_q]) begin
            hold_d  = '0;
            phase_d = '0;
            if (any_req) begin
              owner_d = win;
            end else begin
              state_d = S_IDLE;
              owner_d = '0;
            end
          end else if (hold_q < HOLD_MAX) begin
            hold_d  = hold_q + HOLD_W'(1);
            phase_d = phase_q + PHASE_W'(1);
          end else if (win > owner_q) begin
            owner_d = win;
            hold_d  = '0;
            phase_d = '0;
          end else begin
            hold_d  = HOLD_MAX;
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are derived from next state so led and grant change together.
    own_mode = mode[{owner_d, 1'b0} +: 2];
    grant_d  = '0;
    led_d    = 1'b0;
    if (state_d == S_OWN) begin
      grant_d[owner_d] = 1'b1;
      case (own_mode)
        2'b00:   led_d = 1'b0;
        2'b01:   led_d = 1'b1;
        2'b10:   led_d = ~phase_d[SLOW_BIT];
        default: led_d = ~phase_d[FAST_BIT];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      owner_q <= '0;
      grant_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign grant = grant_q;
  assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// Scoreboard bench for led_arbiter with small prescaler and hold settings.
module tb_led_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] mode = '0;
  logic       led;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       tick;

  led_arbiter #(
    .N_REQ(4), .TICK_DIV(4), .MIN_HOLD(3), .PHASE_W(4), .SLOW_BIT(3), .FAST_BIT(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .led(led), .grant(grant), .owner(owner), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         test;
    int         cyc;
    logic       tk;
    logic [3:0] gr;
    logic [1:0] ow;
    logic       ld;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ne = 0;
  int   cyc0 = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) ne <= ne + 1;

  // Cycle c of a test is the value seen after the (c)th edge following the reset edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= ne) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != ne) begin
        errors++;
        $display("FAIL t%0d c%0d: expectation skipped (edge count %0d, due %0d)",
                 mon_e.test, mon_e.cyc, ne, mon_e.at);
      end else if (tick !== mon_e.tk || grant !== mon_e.gr || owner !== mon_e.ow || led !== mon_e.ld) begin
        errors++;
        $display("FAIL t%0d c%0d: tick/grant/owner/led got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
                 mon_e.test, mon_e.cyc, tick, grant, owner, led,
                 mon_e.tk, mon_e.gr, mon_e.ow, mon_e.ld);
      end
    end
  end

  task automatic push(input int test, input int c, input logic tk, input logic [3:0] gr,
                      input logic [1:0] ow, input logic ld);
    exp_t e;
    e.at = cyc0 + c; e.test = test; e.cyc = c;
    e.tk = tk; e.gr = gr; e.ow = ow; e.ld = ld;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    mode  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc0  = ne;
  endtask

  task automatic wait_cyc(input int c);
    while (ne < cyc0 + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [3:0] g;
    logic [1:0] o;

    // Test 1: prescaler only, no requests.
    do_reset();
    for (int c = 0; c <= 12; c++) push(1, c, (c % 4) == 3, 4'b0000, 2'd0, 1'b0);
    wait_cyc(13);

    // Tests 2-4: grant, hold then preempt, immediate release, idle.
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      if (c < 4)       begin g = 4'b0000; o = 2'd0; end
      else if (c < 16) begin g = 4'b0010; o = 2'd1; end
      else if (c < 20) begin g = 4'b1000; o = 2'd3; end
      else if (c < 24) begin g = 4'b0010; o = 2'd1; end
      else             begin g = 4'b0000; o = 2'd0; end
      push(2, c, (c % 4) == 3, g, o, g != 4'b0000);
    end
    wait_cyc(1);  req = 4'b0010; mode = 8'b0000_0100;
    wait_cyc(5);  req = 4'b1010; mode = 8'b0100_0100;
    wait_cyc(17); req = 4'b0010;
    wait_cyc(21); req = 4'b0000;
    wait_cyc(26);

    // Test 5a: fast blink on requester 0, then live switch to off.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c < 4) push(5, c, (c % 4) == 3, 4'b0000, 2'd0, 1'b0);
      else begin
        k = (c - 4) / 4;
        push(5, c, (c % 4) == 3, 4'b0001, 2'd0, (c <= 36) && (((k / 2) % 2) == 0));
      end
    end
    wait_cyc(1);  req = 4'b0001; mode = 8'b0000_0011;
    wait_cyc(36); mode = 8'b0000_0000;
    wait_cyc(41);

    // Test 5b: slow blink, eight periods on then eight off.
    do_reset();
    for (int c = 0; c <= 70; c++) begin
      if (c < 4) push(6, c, (c % 4) == 3, 4'b0000, 2'd0, 1'b0);
      else begin
        k = (c - 4) / 4;
        push(6, c, (c % 4) == 3, 4'b0001, 2'd0, (k % 16) < 8);
      end
    end
    wait_cyc(1);  req = 4'b0001; mode = 8'b0000_0010;
    wait_cyc(70);

    // Test 6: one-cycle reset while owning; prescaler restarts.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc0  = ne;
    for (int c = 0; c <= 6; c++) begin
      if (c < 4) push(7, c, (c % 4) == 3, 4'b0000, 2'd0, 1'b0);
      else       push(7, c, (c % 4) == 3, 4'b0001, 2'd0, 1'b1);
    end
    wait_cyc(7);

    k = 0;
    while (sb.size() > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
